// File: rtl/nibble_serial_addsub.sv
// Nibble-serial W-bit add/subtract over one shared 4-bit ripple-carry slice, valid/ready on both sides.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output V.

module four_bit_RCA_RCS (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   input  logic       mode,
   output logic [3:0] S,
   output logic       Cout
);
   logic [3:0] bx;
   logic [4:0] c;

   // mode=1 inverts B and forces carry-in to 1, so chained subtraction must not use it
   always_comb begin
      bx   = B ^ {4{mode}};
      c    = '0;
      c[0] = mode | Cin;
      S    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         S[i]   = A[i] ^ bx[i] ^ c[i];
         c[i+1] = (A[i] & bx[i]) | (A[i] & c[i]) | (bx[i] & c[i]);
      end
      Cout = c[4];
   end
endmodule

module nibble_serial_addsub #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] S,
   output logic         Cout,
`ifdef ADDSUB_OVF_EN
   output logic         V,
`endif
   output logic         busy
);
   localparam int unsigned NIB = W / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_next;
   logic [W-1:0]  a_q, bx_q;
   logic          carry;
   logic [IW-1:0] idx;
   logic [3:0]    a_nib, bx_nib, slice_s;
   logic          slice_cout;
   logic          last;

   assign last = (idx == LAST);

   always_comb begin
      a_nib  = '0;
      bx_nib = '0;
      for (int unsigned n = 0; n < NIB; n++) begin
         if (idx == IW'(n)) begin
            a_nib  = a_q[4*n +: 4];
            bx_nib = bx_q[4*n +: 4];
         end
      end
   end

   four_bit_RCA_RCS u_slice (
      .A    (a_nib),
      .B    (bx_nib),
      .Cin  (carry),
      .mode (1'b0),
      .S    (slice_s),
      .Cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         bx_q  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
`ifdef ADDSUB_OVF_EN
         V     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= A;
                  bx_q  <= mode ? ~B : B;
                  carry <= mode;
                  idx   <= '0;
               end
            end
            RUN: begin
               for (int unsigned n = 0; n < NIB; n++) begin
                  if (idx == IW'(n)) S[4*n +: 4] <= slice_s;
               end
               carry <= slice_cout;
               if (last) begin
                  Cout <= slice_cout;
`ifdef ADDSUB_OVF_EN
                  V    <= (a_nib[3] == bx_nib[3]) && (slice_s[3] != a_nib[3]);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: directed table, multi-cycle corner sequences, random ops vs arithmetic model.
module tb_nibble_serial_addsub;
   localparam int unsigned W   = 16;
   localparam int unsigned NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         mode = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] S;
   logic         Cout;
   logic         busy;
`ifdef ADDSUB_OVF_EN
   logic         V;
`endif

   int n_vec = 0;
   int n_mis = 0;

   nibble_serial_addsub #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
`ifdef ADDSUB_OVF_EN
      .V         (V),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] s;
      logic        c;
      logic        v;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   function automatic void model(input logic m, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] s, output logic c, output logic v);
      int unsigned t;
      int r;
      if (!m) begin
         t = int'(a) + int'(b);
         c = (t > 32'd65535);
         r = int'($signed(a)) + int'($signed(b));
      end else begin
         t = (int'(a) - int'(b)) & 32'h0000_FFFF;
         c = (a >= b);
         r = int'($signed(a)) - int'($signed(b));
      end
      s = t[15:0];
      v = (r > 32767) || (r < -32768);
   endfunction

   task automatic start_op(input logic m, input logic [15:0] a, input logic [15:0] b);
      check("in_ready_before_issue", in_ready, 1);
      in_valid = 1'b1;
      mode = m;
      A = a;
      B = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      mode = $urandom_range(0, 1);
      check("busy_after_accept", busy, 1);
      check("in_ready_after_accept", in_ready, 0);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_after_handshake", out_valid, 0);
      check("in_ready_after_handshake", in_ready, 1);
   endtask

   task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                         input int stall, output logic [15:0] s, output logic c, output logic v);
      int n;
      start_op(m, a, b);
      wait_done(n);
      check("latency", n, NIB);
      repeat (stall) begin
         @(posedge clk); #1;
      end
      s = S;
      c = Cout;
`ifdef ADDSUB_OVF_EN
      v = V;
`else
      v = 1'b0;
`endif
      finish_out();
   endtask

   vec_t tbl[8];

   initial begin
      logic [15:0] s, es, a, b, hs;
      logic        c, v, ec, ev, m, hc;
      int          n;

      tbl[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 16'h5000, 16'h0001, 16'h4FFF, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_S", S, 0);
      check("rst_Cout", Cout, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef ADDSUB_OVF_EN
      check("rst_V", V, 0);
`endif

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].m, tbl[i].a, tbl[i].b, i % 3, s, c, v);
         check($sformatf("tbl%0d_S", i), s, tbl[i].s);
         check($sformatf("tbl%0d_Cout", i), c, tbl[i].c);
`ifdef ADDSUB_OVF_EN
         check($sformatf("tbl%0d_V", i), v, tbl[i].v);
`endif
      end

      // Backpressure in DONE with competing in_valid
      start_op(1'b0, 16'hABCD, 16'h1111);
      wait_done(n);
      check("bp_latency", n, NIB);
      hs = S;
      hc = Cout;
      check("bp_S", hs, 16'hBCDE);
      check("bp_Cout", hc, 0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         A = $urandom;
         B = $urandom;
         mode = $urandom_range(0, 1);
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_S_hold", S, 16'hBCDE);
         check("bp_Cout_hold", Cout, 0);
      end
      in_valid = 1'b0;
      finish_out();
      run_op(1'b1, 16'h1000, 16'h0001, 0, s, c, v);
      check("post_bp_S", s, 16'h0FFF);
      check("post_bp_Cout", c, 1);

      // Reset two cycles into RUN
      start_op(1'b0, 16'hFFFF, 16'hFFFF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_S", S, 0);
      check("midrst_Cout", Cout, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      run_op(1'b0, 16'h00FF, 16'h0001, 0, s, c, v);
      check("post_rst_S", s, 16'h0100);
      check("post_rst_Cout", c, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: a = 16'h0000;
            1: a = 16'hFFFF;
            2: a = 16'h8000;
            default: a = $urandom;
         endcase
         b = (i % 4 == 0) ? a : 16'($urandom);
         m = $urandom_range(0, 1);
         model(m, a, b, es, ec, ev);
         run_op(m, a, b, $urandom_range(0, 3), s, c, v);
         check($sformatf("rnd%0d_S", i), s, es);
         check($sformatf("rnd%0d_Cout", i), c, ec);
`ifdef ADDSUB_OVF_EN
         check($sformatf("rnd%0d_V", i), v, ev);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
